// File: rtl/pipeline_perf_monitor.sv
// Run-cycle and pipeline-event counters with auto-stop at a cycle limit, shadow snapshot
// registers and a registered read port.
module pipeline_perf_monitor #(
    parameter int NUM_EVT     = 4,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30,
    parameter int SATURATE    = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               snap_i,
    input  logic [3:0]         rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_EVT-1:0] ovf_o,
    output logic               running_o,
    output logic               done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] WRAP_VAL = (SATURATE != 0) ? ALL_ONES : '0;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CYCLE_LIMIT);
    localparam bit               LIMIT_EN = (CYCLE_LIMIT != 0);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               counting;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   cycle_nxt;
    logic [CNT_W-1:0]   evt_cnt [NUM_EVT];
    logic [CNT_W-1:0]   evt_nxt [NUM_EVT];
    logic [NUM_EVT-1:0] ovf_nxt;
    logic [CNT_W-1:0]   shadow  [NUM_EVT+1];
    logic [CNT_W-1:0]   rd_nxt;

    // Returns {overflow, next value}; an increment from all-ones either wraps or saturates.
    function automatic logic [CNT_W:0] evt_bump(input logic [CNT_W-1:0] cnt);
        if (cnt == ALL_ONES) begin
            return {1'b1, WRAP_VAL};
        end
        return {1'b0, cnt + ONE};
    endfunction

    always_comb begin
        counting  = (state == S_RUN);
        cycle_nxt = cycle_cnt + ONE;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_i) state_nxt = S_RUN;
            S_RUN: begin
                // Reaching the limit wins over a simultaneous drop of start_i.
                if (LIMIT_EN && (cycle_nxt == LIMIT)) begin
                    state_nxt = S_DONE;
                end else if (!start_i) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: if (start_i) state_nxt = S_RUN;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ovf_nxt = ovf_o;
        for (int k = 0; k < NUM_EVT; k++) begin
            evt_nxt[k] = evt_cnt[k];
            if (counting && evt_i[k]) begin
                {ovf_nxt[k], evt_nxt[k]} = evt_bump(evt_cnt[k]);
                ovf_nxt[k] = ovf_nxt[k] | ovf_o[k];
            end
        end
    end

    always_comb begin
        rd_nxt = '0;
        for (int s = 0; s <= NUM_EVT; s++) begin
            if (rd_sel_i == 4'(s)) rd_nxt = shadow[s];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || clear_i) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            ovf_o     <= '0;
            rd_data_o <= '0;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt[k] <= '0;
            for (int s = 0; s <= NUM_EVT; s++) shadow[s] <= '0;
        end else begin
            state     <= state_nxt;
            ovf_o     <= ovf_nxt;
            rd_data_o <= rd_nxt;
            if (counting) cycle_cnt <= cycle_nxt;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt[k] <= evt_nxt[k];
            // Snapshot takes pre-edge values, so this edge's increments are excluded.
            if (snap_i) begin
                shadow[0] <= cycle_cnt;
                for (int k = 0; k < NUM_EVT; k++) shadow[k+1] <= evt_cnt[k];
            end
        end
    end

    assign running_o = (state == S_RUN);
    assign done_o    = (state == S_DONE);

endmodule
